mux_nto1_rr: RTL and testbench
==============================

Name: mux_nto1_rr

Overview:
- Parametrised N:1 channel multiplexer with a registered output. It is the successor to the team's combinational 2:1 select.
- Each input channel carries a valid/ready handshake. The winning channel is chosen either by an explicit select (fixed mode) or by round-robin arbitration.
- It sits between several producer channels and one consumer stage.
- Latency is one clock, with full-throughput back-to-back transfers.

Parameters:
- WIDTH, 8, data width per channel in bits.
- CHANNELS, 4, number of input channels; legal range 2..16.
- SEL_W, $clog2(CHANNELS), localparam derived from CHANNELS; not overridable.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SEL_W  channel index used in fixed mode; ignored in round-robin mode.
- in_data  input  CHANNELS*WIDTH  flattened channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  CHANNELS  per-channel valid.
- in_ready  output  CHANNELS  per-channel ready; at most one bit high per cycle.
- out_data  output  WIDTH  registered selected data.
- out_valid  output  1  registered output valid.
- out_chan  output  SEL_W  index of the channel that produced out_data.
- out_ready  input  1  consumer ready.

Behaviour:
- Reset (rst high at a clk edge) sets out_valid=0, out_data=0, out_chan=0 and the round-robin pointer ptr=0.
- While rst is high, in_ready is forced to all zeros. Any in-flight output word is discarded without being delivered.
- load = ~out_valid | out_ready. The output register may accept a new word only when load is high.
- Fixed mode (mode=0):
  - Candidate is channel sel.
  - Grant occurs when load is high, sel < CHANNELS and in_valid[sel] is high.
  - sel >= CHANNELS means no grant; no error flag is raised.
- Round-robin mode (mode=1):
  - Scan channels ptr, ptr+1, ..., wrapping modulo CHANNELS. Grant the first one with in_valid set, provided load is high.
  - On a grant, ptr <= (granted index + 1) mod CHANNELS; on wrap, ptr returns to 0.
  - With no grant, ptr holds.
- ptr holds its value in fixed mode. Switching mode takes effect in the same cycle; no state is flushed.
- in_ready[g] = 1 only for the granted index g. in_ready is combinational from mode, sel, in_valid, ptr, out_valid and out_ready; it is never asserted without a grant.
- Transfer on channel i occurs when in_valid[i] & in_ready[i].
- On a clk edge with load=1:
  - out_valid <= grant.
  - out_data <= in_data of the granted channel when there is a grant, otherwise it holds.
  - out_chan <= granted index when there is a grant, otherwise it holds.
- On a clk edge with load=0, all output registers hold. out_data and out_chan stay stable while out_valid=1 and out_ready=0.
- Latency: an input accepted in cycle n appears on out_data with out_valid=1 from cycle n+1.
- Throughput: one word per clock when out_ready stays high.
- Simultaneous drain and fill: out_valid=1 with out_ready=1 and a grant in the same cycle replaces the output word with no bubble.
- All channels idle with out_ready=1: out_valid falls to 0 on the next edge.
- No combinational path from in_data to out_data.

Decomposition:
- Shared package mux_pkg holds:
  - constants MODE_FIXED=1'b0 and MODE_RR=1'b1;
  - a function returning the channel slice of the flattened in_data bus.
- One sub-module, rr_arbiter (parameter CHANNELS):
  - inputs: request vector, ptr, enable;
  - outputs: one-hot grant, grant index, grant_any.
- The top level holds ptr, the output register, the mode mux and the handshake logic.

Test Plan:
- Reset: apply rst with all in_valid=1 -> in_ready=0000, out_valid=0, out_data=0, out_chan=0, ptr=0 on the cycle after rst falls.
- Fixed mode, WIDTH=8, CHANNELS=4:
  - Stimulus: mode=0, sel=2, in_data ch2=0xA5, in_valid=0100, out_ready=1.
  - Required: in_ready=0100 in the same cycle; next cycle out_data=0xA5, out_chan=2, out_valid=1.
  - Then sel=1 with in_valid[1]=0 -> in_ready=0000.
- Round-robin fairness:
  - Stimulus: mode=1, in_valid=1111, out_ready=1, ch i data = 0x10+i.
  - Required: out_chan sequence 0,1,2,3,0,1 on consecutive cycles; out_data 0x10,0x11,0x12,0x13,0x10,0x11; no bubbles.
- Round-robin skip and wrap:
  - Stimulus: ptr=3, in_valid=0101.
  - Required: grant channel 0 (wrap), then ptr=1; next grant channel 2, then ptr=3.
- Backpressure:
  - Stimulus: out_valid=1, out_ready=0, in_valid=1111.
  - Required: in_ready=0000; out_data and out_chan held for 3 cycles.
  - Then out_ready=1 -> new word loaded on that edge with no bubble.
- Reset mid-stream: assert rst while out_valid=1 and out_ready=0 -> out_valid=0 next cycle, word dropped, ptr=0, first post-reset round-robin grant goes to the lowest valid channel.

Source files
------------

// File: rtl/mux_nto1_rr_pkg.sv
// ---------------------------------------------------------------------------
// mux_pkg
//   Shared definitions for the N:1 round-robin / fixed-select multiplexer.
//
//   Contents:
//     MODE_FIXED / MODE_RR  - values of the top-level 'mode' input
//     MAX_CHANNELS          - largest legal channel count
//     MAX_WIDTH             - largest data width chan_slice can return
//     BUS_W                 - width of the zero-extended flattened bus that
//                             chan_slice operates on
//     chan_slice()          - extracts channel 'idx' of 'width' bits from a
//                             flattened data bus (channel i at [i*width +: width])
// ---------------------------------------------------------------------------
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  localparam int MAX_CHANNELS = 16;
  localparam int MAX_WIDTH    = 64;
  localparam int BUS_W        = MAX_CHANNELS * MAX_WIDTH;

  // Returns the 'width'-bit slice for channel 'idx', zero-extended to
  // MAX_WIDTH. Bits beyond 'width' and any bit that would fall off the end
  // of the bus read as zero, so the function is safe for any index value.
  function automatic logic [MAX_WIDTH-1:0] chan_slice(
    input logic [BUS_W-1:0] bus,
    input int unsigned      idx,
    input int unsigned      width
  );
    logic [MAX_WIDTH-1:0] r;
    int unsigned          pos;
    r = '0;
    for (int unsigned b = 0; b < MAX_WIDTH; b++) begin
      pos = idx * width + b;
      if ((b < width) && (pos < BUS_W)) begin
        r[b] = bus[pos];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_nto1_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Combinational rotating-priority arbiter. Scans the request vector starting
//   at index 'ptr' and wrapping modulo CHANNELS; the first set request wins.
//   Holds no state: the pointer lives in the parent so it can be frozen in
//   fixed-select mode.
//
//   Ports:
//     req        in   CHANNELS  request vector
//     ptr        in   SEL_W     highest-priority index this cycle (< CHANNELS)
//     enable     in   1         when low, no grant is produced
//     grant      out  CHANNELS  one-hot grant (all zero when grant_any = 0)
//     grant_idx  out  SEL_W     index of the granted request (0 when none)
//     grant_any  out  1         a request was granted
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SEL_W-1:0]    ptr,
  input  logic                enable,
  output logic [CHANNELS-1:0] grant,
  output logic [SEL_W-1:0]    grant_idx,
  output logic                grant_any
);

  int idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = 0;
    for (int k = 0; k < CHANNELS; k++) begin
      // ptr is always a legal index, so one subtraction is enough to wrap.
      idx = int'(32'(ptr)) + k;
      if (idx >= CHANNELS) begin
        idx = idx - CHANNELS;
      end
      if (enable && !grant_any && req[idx]) begin
        grant_any  = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = SEL_W'(idx);
      end
    end
  end

endmodule

// File: rtl/mux_nto1_rr.sv
// ---------------------------------------------------------------------------
// mux_nto1_rr
//   N:1 channel multiplexer with a registered output stage. The winning input
//   channel is picked either by an explicit index (fixed mode) or by a
//   round-robin arbiter, and its word is captured into the output register.
//   One clock of latency, one word per clock when the consumer keeps up.
//
//   Handshake (inputs and output alike): a word moves across an interface on
//   a rising clk edge where both valid and ready are high. A producer holds
//   valid and data stable until that edge; ready may depend combinationally on
//   valid, and this block never raises in_ready on a channel whose in_valid
//   is low.
//
//   Parameters:
//     WIDTH     data bits per channel (up to 64)
//     CHANNELS  number of input channels, 2..16
//
//   Ports:
//     clk        in   1               rising-edge clock
//     rst        in   1               synchronous active-high reset
//     mode       in   1               0 = fixed select, 1 = round-robin
//     sel        in   SEL_W           channel index used in fixed mode
//     in_data    in   CHANNELS*WIDTH  channel i at [i*WIDTH +: WIDTH]
//     in_valid   in   CHANNELS        per-channel valid
//     in_ready   out  CHANNELS        per-channel ready, at most one bit set
//     out_data   out  WIDTH           registered selected word
//     out_valid  out  1               registered output valid
//     out_chan   out  SEL_W           channel that produced out_data
//     out_ready  in   1               consumer ready
// ---------------------------------------------------------------------------
module mux_nto1_rr
  import mux_pkg::*;
#(
  parameter  int WIDTH    = 8,
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  output logic [SEL_W-1:0]          out_chan,
  input  logic                      out_ready
);

  // Round-robin pointer: highest-priority channel for the next arbitration.
  logic [SEL_W-1:0]    ptr;
  logic [SEL_W-1:0]    ptr_next;

  // Output register can take a new word when empty or being drained now.
  logic                load;

  logic                rr_en;
  logic [CHANNELS-1:0] rr_grant;
  logic [SEL_W-1:0]    rr_idx;
  logic                rr_any;

  logic                sel_in_range;
  logic [CHANNELS-1:0] grant_vec;
  logic [SEL_W-1:0]    grant_idx;
  logic                grant_any;
  logic [WIDTH-1:0]    grant_data;

  assign load = ~out_valid | out_ready;

  // ---------------------------------------------------------------------
  // Round-robin arbitration
  // ---------------------------------------------------------------------
  assign rr_en = load & (mode == MODE_RR) & ~rst;

  rr_arbiter #(
    .CHANNELS (CHANNELS)
  ) u_arb (
    .req       (in_valid),
    .ptr       (ptr),
    .enable    (rr_en),
    .grant     (rr_grant),
    .grant_idx (rr_idx),
    .grant_any (rr_any)
  );

  // ---------------------------------------------------------------------
  // Mode mux: fixed select or arbiter result
  // ---------------------------------------------------------------------
  // For non-power-of-two channel counts sel can name a channel that does not
  // exist; that is simply "no grant".
  assign sel_in_range = (int'(32'(sel)) < CHANNELS);

  always_comb begin
    grant_vec = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    if (!rst) begin
      if (mode == MODE_RR) begin
        grant_vec = rr_grant;
        grant_idx = rr_idx;
        grant_any = rr_any;
      end else if (load && sel_in_range) begin
        if (in_valid[sel]) begin
          grant_vec[sel] = 1'b1;
          grant_idx      = sel;
          grant_any      = 1'b1;
        end
      end
    end
  end

  // Ready goes only to the granted channel; grant_vec is already zero in
  // reset, with no load, or without a matching valid.
  assign in_ready = grant_vec;

  // ---------------------------------------------------------------------
  // Datapath: slice the granted channel out of the flattened bus. The only
  // path from in_data to out_data runs through the output register.
  // ---------------------------------------------------------------------
  assign grant_data = WIDTH'(chan_slice(BUS_W'(in_data),
                                        int'(32'(grant_idx)),
                                        WIDTH));

  // Pointer advances past the winner, wrapping to 0 after the last channel.
  always_comb begin
    if (int'(32'(grant_idx)) == CHANNELS - 1) begin
      ptr_next = '0;
    end else begin
      ptr_next = grant_idx + SEL_W'(1);
    end
  end

  // ---------------------------------------------------------------------
  // State: output register and round-robin pointer
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      // Any word waiting in the output register is dropped here.
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr       <= '0;
    end else begin
      if (load) begin
        out_valid <= grant_any;
        if (grant_any) begin
          out_data <= grant_data;
          out_chan <= grant_idx;
        end
      end
      // Fixed-mode grants leave the rotation untouched, so switching back to
      // round-robin resumes where it left off.
      if (grant_any && (mode == MODE_RR)) begin
        ptr <= ptr_next;
      end
    end
  end

endmodule

// File: tb/tb_mux_nto1_rr.sv
// ---------------------------------------------------------------------------
// tb_mux_nto1_rr
//   Self-checking bench for mux_nto1_rr (WIDTH=8, CHANNELS=4).
//   Directed phases for reset, fixed select, round-robin fairness, skip/wrap,
//   backpressure and mid-stream reset, then a randomised phase. A monitor on
//   the falling edge predicts in_ready from a small reference model, pushes
//   the expected {chan, data} word when a grant is due, and pops/compares it
//   when the consumer takes the output.
// ---------------------------------------------------------------------------
module tb_mux_nto1_rr;

  localparam int W  = 8;
  localparam int CH = 4;
  localparam int SW = 2;

  // ---------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------
  logic            clk;
  logic            rst;
  logic            mode;
  logic [SW-1:0]   sel;
  logic [CH*W-1:0] in_data;
  logic [CH-1:0]   in_valid;
  logic [CH-1:0]   in_ready;
  logic [W-1:0]    out_data;
  logic            out_valid;
  logic [SW-1:0]   out_chan;
  logic            out_ready;

  logic [W-1:0]    d [CH];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < CH; i++) begin
      in_data[i*W +: W] = d[i];
    end
  end

  mux_nto1_rr #(
    .WIDTH    (W),
    .CHANNELS (CH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_chan  (out_chan),
    .out_ready (out_ready)
  );

  // ---------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Driver helpers: inputs change 1 time unit after the rising edge.
  // ---------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rr_data();
    for (int i = 0; i < CH; i++) begin
      d[i] = W'(8'h10 + i);
    end
  endtask

  // ---------------------------------------------------------------------
  // Scoreboard monitor with reference model
  // ---------------------------------------------------------------------
  logic [SW+W-1:0] exp_q[$];
  logic            m_ov  = 1'b0;
  int              m_ptr = 0;

  always @(negedge clk) begin
    logic [CH-1:0]   eg;
    logic [SW+W-1:0] e;
    int              gi;
    int              j;
    bit              gany;

    // Output side.
    check("out_valid", 32'(out_valid), 32'(m_ov));
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_pending", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check("sb_word", 32'({out_chan, out_data}), 32'(e));
      end
    end

    // Input side: expected grant this cycle.
    eg   = '0;
    gi   = 0;
    gany = 1'b0;
    if (!rst && (!m_ov || out_ready)) begin
      if (mode) begin
        for (int k = 0; k < CH; k++) begin
          j = (m_ptr + k) % CH;
          if (!gany && in_valid[j]) begin
            gany = 1'b1;
            gi   = j;
          end
        end
      end else if (in_valid[sel]) begin
        gany = 1'b1;
        gi   = int'(sel);
      end
    end
    if (gany) eg[gi] = 1'b1;
    check("in_ready", 32'(in_ready), 32'(eg));

    // Advance the model to the state after the coming rising edge.
    if (rst) begin
      exp_q.delete();
      m_ov  = 1'b0;
      m_ptr = 0;
    end else if (!m_ov || out_ready) begin
      m_ov = gany;
      if (gany) begin
        exp_q.push_back({SW'(gi), d[gi]});
        if (mode) m_ptr = (gi + 1) % CH;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  initial begin
    rst       = 1'b1;
    mode      = 1'b0;
    sel       = '0;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < CH; i++) d[i] = 8'h00;

    // Reset with every channel requesting.
    repeat (3) tick();
    rst      = 1'b0;
    in_valid = 4'b0000;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'h00);
    check("rst_out_chan",  32'(out_chan),  32'd0);
    check("rst_ptr",       32'(dut.ptr),   32'd0);

    // Fixed mode, sel = 2.
    tick();
    mode      = 1'b0;
    sel       = 2'd2;
    d[2]      = 8'hA5;
    in_valid  = 4'b0100;
    out_ready = 1'b1;
    @(negedge clk);
    check("fix_in_ready", 32'(in_ready), 32'b0100);
    tick();
    sel = 2'd1;
    @(negedge clk);
    check("fix_out_data",  32'(out_data),  32'hA5);
    check("fix_out_chan",  32'(out_chan),  32'd2);
    check("fix_out_valid", 32'(out_valid), 32'd1);
    check("fix_idle_sel",  32'(in_ready),  32'b0000);
    check("fix_ptr_hold",  32'(dut.ptr),   32'd0);

    // Round-robin fairness with all channels requesting.
    tick();
    set_rr_data();
    mode     = 1'b1;
    in_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("rr_in_ready", 32'(in_ready), 32'(4'b0001 << (k % 4)));
      if (k > 0) begin
        check("rr_out_valid", 32'(out_valid), 32'd1);
        check("rr_out_chan",  32'(out_chan),  32'((k - 1) % 4));
        check("rr_out_data",  32'(out_data),  32'(8'h10 + ((k - 1) % 4)));
      end
      tick();
    end
    in_valid = 4'b0000;
    @(negedge clk);
    check("rr_last_chan", 32'(out_chan), 32'd1);
    check("rr_last_data", 32'(out_data), 32'h11);
    check("rr_ptr",       32'(dut.ptr),  32'd2);

    // Skip and wrap: bring ptr to 3, then request 0101.
    tick();
    in_valid = 4'b0100;
    @(negedge clk);
    check("sw_pre_ready", 32'(in_ready), 32'b0100);
    tick();
    in_valid = 4'b0101;
    @(negedge clk);
    check("sw_ptr3",   32'(dut.ptr),  32'd3);
    check("sw_wrap",   32'(in_ready), 32'b0001);
    tick();
    @(negedge clk);
    check("sw_ptr1",   32'(dut.ptr),  32'd1);
    check("sw_chan0",  32'(out_chan), 32'd0);
    check("sw_skip",   32'(in_ready), 32'b0100);
    tick();
    in_valid = 4'b0000;
    @(negedge clk);
    check("sw_ptr3b",  32'(dut.ptr),  32'd3);
    check("sw_chan2",  32'(out_chan), 32'd2);

    // Backpressure: load one word, then stall for three cycles.
    tick();
    in_valid  = 4'b1111;
    out_ready = 1'b0;
    @(negedge clk);
    check("bp_load_ready", 32'(in_ready), 32'b1000);
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clk);
      check("bp_in_ready",  32'(in_ready),  32'b0000);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_chan",  32'(out_chan),  32'd3);
      check("bp_out_data",  32'(out_data),  32'h13);
    end
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", 32'(in_ready), 32'b0001);
    tick();
    @(negedge clk);
    check("bp_next_valid", 32'(out_valid), 32'd1);
    check("bp_next_chan",  32'(out_chan),  32'd0);
    check("bp_next_data",  32'(out_data),  32'h10);

    // Reset while a word is stalled in the output register.
    tick();
    out_ready = 1'b0;
    @(negedge clk);
    check("mr_stall_valid", 32'(out_valid), 32'd1);
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("mr_rst_ready", 32'(in_ready), 32'b0000);
    tick();
    rst      = 1'b0;
    in_valid = 4'b0110;
    @(negedge clk);
    check("mr_out_valid", 32'(out_valid), 32'd0);
    check("mr_ptr",       32'(dut.ptr),   32'd0);
    check("mr_ready",     32'(in_ready),  32'b0010);
    tick();
    in_valid = 4'b0000;
    @(negedge clk);
    check("mr_first_chan", 32'(out_chan),  32'd1);
    check("mr_first_data", 32'(out_data),  32'h11);
    check("mr_first_val",  32'(out_valid), 32'd1);

    // Randomised traffic; the monitor does all the checking here.
    for (int n = 0; n < 400; n++) begin
      tick();
      rst       = ($urandom_range(0, 99) == 0);
      mode      = 1'($urandom_range(0, 1));
      sel       = SW'($urandom_range(0, CH - 1));
      in_valid  = CH'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < CH; i++) d[i] = W'($urandom_range(0, 255));
    end

    // Drain.
    tick();
    rst       = 1'b0;
    in_valid  = 4'b0000;
    out_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
